// File: rtl/model_pwm_pkg.sv
// Shared widths and carrier direction encoding for the PWM driver.
// Used by model_pwm_driver and model_ce_prescaler.
package model_pwm_pkg;

  localparam int PWM_WIDTH_DEF    = 16;
  localparam int CE_DIV_WIDTH_DEF = 16;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/model_ce_prescaler.sv
// Model-step strobe generator: one ce pulse every ce_div+1 cycles.
// Held idle (count and strobe at zero) while enable is low.
module model_ce_prescaler
  import model_pwm_pkg::*;
#(
  parameter int CE_DIV_WIDTH = CE_DIV_WIDTH_DEF
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [CE_DIV_WIDTH-1:0] ce_div,
  output logic                    ce
);

  logic [CE_DIV_WIDTH-1:0] cnt_q;
  logic                    ce_q;

  // >= so a ce_div lowered mid-count still wraps promptly
  always_ff @(posedge aclk) begin
    if (!resetn || !enable) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else if (cnt_q >= ce_div) begin
      cnt_q <= '0;
      ce_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      ce_q  <= 1'b0;
    end
  end

  assign ce = ce_q & enable;

endmodule

// File: rtl/model_pwm_driver.sv
// PWM switch driver for a stepped converter model, shadowed duty via AXI-Stream.
// Define PWM_CENTER_ALIGNED_EN for a triangle carrier; default is sawtooth.
module model_pwm_driver
  import model_pwm_pkg::*;
#(
  parameter int PWM_WIDTH    = PWM_WIDTH_DEF,
  parameter int CE_DIV_WIDTH = CE_DIV_WIDTH_DEF
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [CE_DIV_WIDTH-1:0] ce_div,
  input  logic [PWM_WIDTH-1:0]    period,
  input  logic [PWM_WIDTH-1:0]    s_duty_tdata,
  input  logic                    s_duty_tvalid,
  output logic                    s_duty_tready,
  output logic                    ce,
  output logic                    s1,
  output logic                    cycle_start,
  output logic [PWM_WIDTH-1:0]    duty_active
);

  typedef logic [PWM_WIDTH-1:0] pwm_t;

  pwm_t cnt_q;
  pwm_t period_q;
  pwm_t duty_q;
  pwm_t shadow_q;
  logic pending_q;
  logic rdy_q;
  logic s1_q;

  pwm_t cnt_n;
  pwm_t period_n;
  pwm_t duty_n;
  logic wrap;
  logic boundary;
  logic load;
  logic accept;
  logic s1_n;

  // Duty above period+1 cannot produce more on-time than a full period
  function automatic pwm_t sat(input pwm_t d, input pwm_t p);
    logic [PWM_WIDTH:0] lim;
    lim = {1'b0, p} + 1'b1;
    if ({1'b0, d} > lim) sat = lim[PWM_WIDTH-1:0];
    else                 sat = d;
  endfunction

  model_ce_prescaler #(
    .CE_DIV_WIDTH(CE_DIV_WIDTH)
  ) u_presc (
    .aclk  (aclk),
    .resetn(resetn),
    .enable(enable),
    .ce_div(ce_div),
    .ce    (ce)
  );

`ifdef PWM_CENTER_ALIGNED_EN
  dir_e dir_q;
  dir_e dir_n;

  always_comb begin
    cnt_n = cnt_q;
    dir_n = dir_q;
    wrap  = 1'b0;
    if (period_q == '0) begin
      cnt_n = '0;
      dir_n = UP;
      wrap  = 1'b1;
    end else if (dir_q == UP && cnt_q < period_q) begin
      cnt_n = cnt_q + 1'b1;
    end else if (cnt_q <= pwm_t'(1)) begin
      cnt_n = '0;
      dir_n = UP;
      wrap  = 1'b1;
    end else begin
      cnt_n = cnt_q - 1'b1;
      dir_n = DOWN;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn || !enable) dir_q <= UP;
    else if (ce)            dir_q <= dir_n;
  end
`else
  always_comb begin
    cnt_n = cnt_q + 1'b1;
    wrap  = 1'b0;
    if (cnt_q >= period_q) begin
      cnt_n = '0;
      wrap  = 1'b1;
    end
  end
`endif

  assign boundary = ce & wrap;
  assign load     = enable ? boundary : 1'b1;
  assign accept   = s_duty_tvalid & s_duty_tready;

  always_comb begin
    duty_n   = (load && pending_q) ? shadow_q : duty_q;
    period_n = load ? period : period_q;
    s1_n     = cnt_n < sat(duty_n, period_n);
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      rdy_q     <= 1'b0;
      s1_q      <= 1'b0;
    end else begin
      rdy_q    <= 1'b1;
      duty_q   <= duty_n;
      period_q <= period_n;
      if (accept) begin
        shadow_q  <= s_duty_tdata;
        pending_q <= 1'b1;
      end else if (load) begin
        pending_q <= 1'b0;
      end
      if (!enable) begin
        cnt_q <= '0;
        s1_q  <= 1'b0;
      end else if (ce) begin
        cnt_q <= cnt_n;
        s1_q  <= s1_n;
      end
    end
  end

  assign s_duty_tready = rdy_q & ~pending_q;
  assign s1            = s1_q & enable;
  assign cycle_start   = boundary;
  assign duty_active   = sat(duty_q, period_q);

endmodule

// File: doc/model_pwm_driver.md
MODEL_PWM_DRIVER -- requirements
Module: model_pwm_driver

Interface
REQ-001 Parameter PWM_WIDTH, default 16, sets the width of the carrier counter, period and duty.
REQ-002 Parameter CE_DIV_WIDTH, default 16, sets the width of the model-step prescaler.
REQ-003 aclk  in  1  system clock; all logic SHALL be rising-edge aclk.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 enable  in  1  run control; low holds the timing logic idle.
REQ-006 ce_div  in  CE_DIV_WIDTH  model step length minus one, in aclk cycles.
REQ-007 period  in  PWM_WIDTH  carrier terminal count, in model steps.
REQ-008 s_duty_tdata  in  PWM_WIDTH  requested duty, in model steps.
REQ-009 s_duty_tvalid  in  1, and s_duty_tready  out  1: AXI-Stream handshake for duty.
REQ-010 ce  out  1  model step strobe for the downstream converter model.
REQ-011 s1  out  1  switch command; sampled downstream when ce=1.
REQ-012 cycle_start  out  1  one-cycle pulse at each carrier boundary.
REQ-013 duty_active  out  PWM_WIDTH  duty currently applied, after saturation.

Function
REQ-014 Prescaler SHALL count 0..ce_div, assert ce for one cycle when the count equals ce_div, then wrap to 0. With ce_div=0, ce SHALL be high every cycle while enable=1.
REQ-015 The carrier counter SHALL advance only on cycles where ce=1.
REQ-016 s1 SHALL be registered and updated on ce cycles as (next carrier count < next duty_active).
REQ-017 A duty is accepted when tvalid and tready are both high; it SHALL be stored in a one-entry shadow register and set a pending flag.
REQ-018 tready SHALL equal NOT pending. There is no bypass: a value accepted on a boundary cycle SHALL apply at the following boundary.
REQ-019 At a boundary (ce=1 and the counter wraps), pending shadow duty SHALL load into duty_active, pending SHALL clear, and period SHALL be latched into period_active.
REQ-020 Saturation: a duty greater than period_active+1 SHALL be applied as period_active+1 (s1 constantly 1). Duty 0 SHALL keep s1 constantly 0.
REQ-021 period_active=0: the counter SHALL stay at 0 and every ce SHALL be a boundary.
REQ-022 cycle_start SHALL be asserted in the same cycle as the boundary ce.
REQ-023 enable=0: prescaler and carrier SHALL be forced to 0, and ce, s1 and cycle_start SHALL be 0. The handshake stays live, and pending duty plus period SHALL transfer to active every cycle.
REQ-024 After enable rises, the first ce SHALL occur ce_div+1 cycles later.

Reset
REQ-025 resetn=0 SHALL clear the prescaler, carrier, shadow, pending, duty_active and period_active, and drive ce=0, s1=0, cycle_start=0, s_duty_tready=0.
REQ-026 s_duty_tready SHALL be 1 from the first cycle after reset release.
REQ-027 Reset asserted mid-period SHALL discard any pending duty.

Configuration
REQ-028 Macro PWM_CENTER_ALIGNED_EN defined: the carrier SHALL count up 0..period_active, then down to 0, so one carrier period is 2*period_active model steps. The boundary SHALL be the step at which the count reaches 0 while counting down, and the duty saturation limit SHALL be period_active+1.
REQ-029 Macro undefined: the carrier SHALL be a sawtooth 0..period_active, with the boundary on wrap to 0.

Structure
REQ-030 Shared package model_pwm_pkg SHALL hold the default widths and the carrier direction encoding (UP, DOWN).
REQ-031 The prescaler SHALL be the sub-module model_ce_prescaler (inputs enable, ce_div; output ce).

Verification
REQ-032 ce_div=3, enable=1 -> ce high exactly once every 4 cycles. Same with ce_div=0 -> ce high continuously.
REQ-033 Sawtooth, period=9, duty=4 -> s1 high for 4 of every 10 ce, and cycle_start once every 10 ce.
REQ-034 Send duty=2 mid-period, then a second duty=7 -> the second transfer sees tready=0 until the boundary, 2 applies at the first boundary, and 7 at the next.
REQ-035 period=5, duty=200 -> duty_active=6 and s1 constantly 1. duty=0 -> s1 constantly 0.
REQ-036 Reset pulsed mid-period with a pending duty -> all outputs 0, duty_active=0, and the pending value lost.
REQ-037 PWM_CENTER_ALIGNED_EN, period=4, duty=2 -> count 0,1,2,3,4,3,2,1,0 with s1 high at counts 0 and 1, and cycle_start at each return to 0.
